// File: rtl/amm_pkg.sv
// Shared types and helpers for the Avalon-MM slave register endpoint.
package amm_pkg;

    localparam int AMM_DW  = 32;
    localparam int AMM_BEW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, TURN} amm_slv_state_t;

    function automatic logic [AMM_DW-1:0] amm_be_merge(
        input logic [AMM_DW-1:0]  old,
        input logic [AMM_DW-1:0]  wdata,
        input logic [AMM_BEW-1:0] be
    );
        logic [AMM_DW-1:0] res;
        res = old;
        for (int b = 0; b < AMM_BEW; b++) begin
            if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/amm_slave_regs_if.sv
// Avalon-MM slave-side signal bundle; the master drives requests, the slave answers.
interface amm_slave_regs_if;
    import amm_pkg::*;

    logic [AMM_DW-1:0]  s_address;
    logic               s_read;
    logic               s_write;
    logic [AMM_DW-1:0]  s_writedata;
    logic [AMM_BEW-1:0] s_byteenable;
    logic [AMM_DW-1:0]  s_readdata;
    logic               s_waitrequest;

    modport master (
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        input  s_readdata, s_waitrequest
    );

    modport slave (
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        output s_readdata, s_waitrequest
    );

endinterface

// File: rtl/amm_regs_bank.sv
// RW register storage with byte-enable merge, one-cycle write strobes and the
// combinational read mux over RW registers, RO status words and unmapped space.
module amm_regs_bank
    import amm_pkg::*;
#(
    parameter int                P_NREGS    = 8,
    parameter int                P_NSTAT    = 4,
    parameter logic [AMM_DW-1:0] P_RST_VAL  = 32'h0000_0000,
    parameter logic [AMM_DW-1:0] P_UNMAPPED = 32'hDEAD_BEEF
) (
    input  logic                      o_clk,
    input  logic                      i_reset,
    input  logic                      wr_en_i,
    input  logic [31:0]               wr_idx_i,
    input  logic [AMM_DW-1:0]         wdata_i,
    input  logic [AMM_BEW-1:0]        be_i,
    input  logic [31:0]               rd_idx_i,
    output logic [AMM_DW-1:0]         rd_data_o,
    output logic [AMM_DW*P_NREGS-1:0] o_regs,
    output logic [P_NREGS-1:0]        o_wstb,
    input  logic [AMM_DW*(P_NSTAT > 0 ? P_NSTAT : 1)-1:0] i_status
);

    logic [AMM_DW-1:0]  regs_q [P_NREGS];
    logic [P_NREGS-1:0] wstb_q;

    // Strobe pulses even for an all-zero byteenable: the access itself is the event.
    always_ff @(posedge o_clk) begin
        if (i_reset) begin
            for (int k = 0; k < P_NREGS; k++) regs_q[k] <= P_RST_VAL;
            wstb_q <= '0;
        end else begin
            wstb_q <= '0;
            for (int k = 0; k < P_NREGS; k++) begin
                if (wr_en_i && wr_idx_i == 32'(k)) begin
                    regs_q[k] <= amm_be_merge(regs_q[k], wdata_i, be_i);
                    wstb_q[k] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < P_NREGS; g++) begin : g_flat
        assign o_regs[AMM_DW*g +: AMM_DW] = regs_q[g];
    end

    assign o_wstb = wstb_q;

    always_comb begin
        rd_data_o = P_UNMAPPED;
        for (int k = 0; k < P_NREGS; k++) begin
            if (rd_idx_i == 32'(k)) rd_data_o = regs_q[k];
        end
        for (int k = 0; k < P_NSTAT; k++) begin
            if (rd_idx_i == 32'(P_NREGS + k)) rd_data_o = i_status[AMM_DW*k +: AMM_DW];
        end
    end

endmodule

// File: rtl/amm_slave_regs.sv
// Avalon-MM slave endpoint: RW register bank plus RO status window, with
// P_WAIT wait states, a single-cycle acknowledge and a turnaround cycle.
module amm_slave_regs
    import amm_pkg::*;
#(
    parameter int                P_NREGS    = 8,
    parameter int                P_NSTAT    = 4,
    parameter int                P_WAIT     = 0,
    parameter logic [AMM_DW-1:0] P_RST_VAL  = 32'h0000_0000,
    parameter logic [AMM_DW-1:0] P_UNMAPPED = 32'hDEAD_BEEF
) (
    input  logic                      o_clk,
    input  logic                      i_reset,
    amm_slave_regs_if.slave           s,
    output logic [AMM_DW*P_NREGS-1:0] o_regs,
    output logic [P_NREGS-1:0]        o_wstb,
    input  logic [AMM_DW*(P_NSTAT > 0 ? P_NSTAT : 1)-1:0] i_status
);

    if (P_WAIT < 0 || P_WAIT > 15) begin : g_bad_wait
        $error("amm_slave_regs: P_WAIT must be within 0..15");
    end
    if (P_NREGS + P_NSTAT > 128) begin : g_bad_map
        $error("amm_slave_regs: P_NREGS+P_NSTAT must not exceed 128");
    end

    amm_slv_state_t    state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AMM_DW-1:0] rdata_q, rdata_d;
    logic [AMM_DW-1:0] bank_rdata;
    logic [31:0]       idx;
    logic              req;
    logic              rd_load;
    logic              wreq;
    logic              wr_en;

    assign idx   = {2'b00, s.s_address[31:2]};
    assign req   = s.s_read | s.s_write;
    assign wr_en = (state_q == ACK) && s.s_write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wreq    = 1'b1;
        rd_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (P_WAIT > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(P_WAIT);
                    end else begin
                        state_d = ACK;
                        rd_load = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A master that withdraws mid-wait gets no side effect.
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ACK;
                    cnt_d   = '0;
                    rd_load = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                wreq    = 1'b0;
                state_d = TURN;
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read-and-write together is a write; readdata keeps its old value.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_load && s.s_read && !s.s_write) rdata_d = bank_rdata;
    end

    always_ff @(posedge o_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign s.s_waitrequest = wreq;
    assign s.s_readdata    = rdata_q;

    amm_regs_bank #(
        .P_NREGS    (P_NREGS),
        .P_NSTAT    (P_NSTAT),
        .P_RST_VAL  (P_RST_VAL),
        .P_UNMAPPED (P_UNMAPPED)
    ) u_bank (
        .o_clk     (o_clk),
        .i_reset   (i_reset),
        .wr_en_i   (wr_en),
        .wr_idx_i  (idx),
        .wdata_i   (s.s_writedata),
        .be_i      (s.s_byteenable),
        .rd_idx_i  (idx),
        .rd_data_o (bank_rdata),
        .o_regs    (o_regs),
        .o_wstb    (o_wstb),
        .i_status  (i_status)
    );

endmodule

// File: tb/tb_amm_slave_regs.sv
// Bench for amm_slave_regs: one instance with no wait states, one with three.
module tb_amm_slave_regs;
    import amm_pkg::*;

    logic o_clk = 1'b0;
    always #5 o_clk = ~o_clk;

    logic         rst0, rst3;
    logic         sel, rd, wr;
    logic [31:0]  addr, wdata;
    logic [3:0]   be;
    logic [127:0] status;
    logic [255:0] regs0, regs3;
    logic [7:0]   wstb0, wstb3;

    amm_slave_regs_if if0 ();
    amm_slave_regs_if if3 ();

    assign if0.s_address    = addr;
    assign if0.s_writedata  = wdata;
    assign if0.s_byteenable = be;
    assign if0.s_read       = rd & ~sel;
    assign if0.s_write      = wr & ~sel;
    assign if3.s_address    = addr;
    assign if3.s_writedata  = wdata;
    assign if3.s_byteenable = be;
    assign if3.s_read       = rd & sel;
    assign if3.s_write      = wr & sel;

    amm_slave_regs #(.P_NREGS(8), .P_NSTAT(4), .P_WAIT(0)) dut0 (
        .o_clk(o_clk), .i_reset(rst0), .s(if0), .o_regs(regs0), .o_wstb(wstb0), .i_status(status)
    );
    amm_slave_regs #(.P_NREGS(8), .P_NSTAT(4), .P_WAIT(3)) dut3 (
        .o_clk(o_clk), .i_reset(rst3), .s(if3), .o_regs(regs3), .o_wstb(wstb3), .i_status(status)
    );

    logic        wq;
    logic [31:0] rdat;
    logic [7:0]  wstb_s;
    assign wq     = sel ? if3.s_waitrequest : if0.s_waitrequest;
    assign rdat   = sel ? if3.s_readdata    : if0.s_readdata;
    assign wstb_s = sel ? wstb3 : wstb0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    typedef struct {
        logic        s;
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        int          ack;
        logic        crd;
        logic [31:0] rdat;
        logic [7:0]  wstb;
    } vec_t;

    function automatic vec_t mk(logic s_, logic r_, logic w_, logic [31:0] a_, logic [31:0] d_,
                                logic [3:0] b_, int ack_, logic crd_, logic [31:0] rd_, logic [7:0] ws_);
        vec_t v;
        v.s = s_; v.r = r_; v.w = w_; v.a = a_; v.d = d_; v.b = b_;
        v.ack = ack_; v.crd = crd_; v.rdat = rd_; v.wstb = ws_;
        return v;
    endfunction

    // Starts in an IDLE cycle; returns the acknowledge cycle index (-1 on timeout)
    // and the strobe seen in the cycle after acknowledge; ends in the next IDLE cycle.
    task automatic xact(input vec_t v, output int ack_c, output logic [31:0] rdv, output logic [7:0] ws);
        sel = v.s; rd = v.r; wr = v.w; addr = v.a; wdata = v.d; be = v.b;
        ack_c = -1;
        rdv   = '0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge o_clk); #1;
            if (!wq) begin
                ack_c = c;
                rdv   = rdat;
                break;
            end
        end
        @(posedge o_clk); #1;
        ws = wstb_s;
        rd = 1'b0;
        wr = 1'b0;
        @(posedge o_clk); #1;
    endtask

    vec_t        vt [14];
    int          ac;
    logic [31:0] rv;
    logic [7:0]  ws;
    logic [5:0]  wqv;
    logic [31:0] w_ack, w_turn;
    logic        acc_wq;
    logic [7:0]  acc_ws;

    initial begin
        rst0 = 1'b1; rst3 = 1'b1;
        sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
        status = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h1111_1111};

        vt[0]  = mk(0, 1, 0, 32'h00, 32'h0,         4'h0, 1, 1, 32'h0000_0000, 8'h00);
        vt[1]  = mk(0, 0, 1, 32'h04, 32'h1234_5678, 4'h5, 1, 0, 32'h0,         8'h02);
        vt[2]  = mk(0, 1, 0, 32'h04, 32'h0,         4'h0, 1, 1, 32'h0034_0078, 8'h00);
        vt[3]  = mk(0, 1, 0, 32'h24, 32'h0,         4'h0, 1, 1, 32'hCAFE_F00D, 8'h00);
        vt[4]  = mk(0, 0, 1, 32'h24, 32'hFFFF_FFFF, 4'hF, 1, 0, 32'h0,         8'h00);
        vt[5]  = mk(0, 1, 0, 32'h24, 32'h0,         4'h0, 1, 1, 32'hCAFE_F00D, 8'h00);
        vt[6]  = mk(0, 1, 0, 32'h40, 32'h0,         4'h0, 1, 1, 32'hDEAD_BEEF, 8'h00);
        vt[7]  = mk(0, 1, 1, 32'h0C, 32'hAABB_CCDD, 4'hF, 1, 1, 32'hDEAD_BEEF, 8'h08);
        vt[8]  = mk(0, 1, 0, 32'h0C, 32'h0,         4'h0, 1, 1, 32'hAABB_CCDD, 8'h00);
        vt[9]  = mk(0, 0, 1, 32'h08, 32'hFFFF_FFFF, 4'h0, 1, 0, 32'h0,         8'h04);
        vt[10] = mk(0, 1, 0, 32'h08, 32'h0,         4'h0, 1, 1, 32'h0000_0000, 8'h00);
        vt[11] = mk(1, 0, 1, 32'h1C, 32'hA5A5_A5A5, 4'hF, 4, 0, 32'h0,         8'h80);
        vt[12] = mk(1, 1, 0, 32'h1C, 32'h0,         4'h0, 4, 1, 32'hA5A5_A5A5, 8'h00);
        vt[13] = mk(1, 1, 0, 32'h20, 32'h0,         4'h0, 4, 1, 32'h1111_1111, 8'h00);

        @(posedge o_clk); @(posedge o_clk); #1;
        chk("rst_wq0",   if0.s_waitrequest, 1'b1);
        chk("rst_rd0",   if0.s_readdata, 32'h0);
        chk("rst_wstb0", wstb0, 8'h00);
        chk("rst_regs0", regs0, 256'h0);
        chk("rst_wq3",   if3.s_waitrequest, 1'b1);
        chk("rst_regs3", regs3, 256'h0);
        rst0 = 1'b0; rst3 = 1'b0;
        @(posedge o_clk); #1;

        for (int i = 0; i < 14; i++) begin
            xact(vt[i], ac, rv, ws);
            chk($sformatf("v%0d_ack", i), ac, vt[i].ack);
            if (vt[i].crd) chk($sformatf("v%0d_rdata", i), rv, vt[i].rdat);
            chk($sformatf("v%0d_wstb", i), ws, vt[i].wstb);
        end
        chk("w3_after_both", regs0[3*32 +: 32], 32'hAABB_CCDD);

        // P_WAIT=3 write: ack only in cycle 4, register and strobe in cycle 5.
        sel = 1'b1; wr = 1'b1; addr = 32'h18; wdata = 32'h0102_0304; be = 4'hF;
        wqv = '0; w_ack = '0; w_turn = '0; ws = '0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge o_clk); #1;
            wqv[c-1] = wq;
            if (c == 4) w_ack = regs3[6*32 +: 32];
            if (c == 5) begin
                w_turn = regs3[6*32 +: 32];
                ws     = wstb3;
                wr     = 1'b0;
            end
        end
        chk("w3_wq_seq",  wqv[4:0], 5'b10111);
        chk("w3_reg_ack", w_ack, 32'h0);
        chk("w3_reg_upd", w_turn, 32'h0102_0304);
        chk("w3_wstb",    ws, 8'h40);
        @(posedge o_clk); #1;
        chk("w3_wstb_1cyc", wstb3, 8'h00);

        // Back-to-back writes with s_write held through the turnaround.
        sel = 1'b0; wr = 1'b1; addr = 32'h10; wdata = 32'h0000_1111; be = 4'hF;
        wqv = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge o_clk); #1;
            wqv[c-1] = wq;
            if (c == 2) begin
                addr  = 32'h14;
                wdata = 32'h2222_0000;
            end
            if (c == 5) wr = 1'b0;
        end
        chk("b2b_wq_seq", wqv, 6'b110110);
        chk("b2b_word4",  regs0[4*32 +: 32], 32'h0000_1111);
        chk("b2b_word5",  regs0[5*32 +: 32], 32'h2222_0000);

        // Request withdrawn during WAIT: no acknowledge, no write.
        sel = 1'b1; wr = 1'b1; addr = 32'h00; wdata = 32'hFFFF_FFFF; be = 4'hF;
        @(posedge o_clk); #1;
        @(posedge o_clk); #1;
        wr = 1'b0;
        acc_wq = 1'b1; acc_ws = '0;
        for (int c = 3; c <= 8; c++) begin
            @(posedge o_clk); #1;
            acc_wq = acc_wq & wq;
            acc_ws = acc_ws | wstb3;
        end
        chk("drop_no_ack",  acc_wq, 1'b1);
        chk("drop_no_wstb", acc_ws, 8'h00);
        chk("drop_word0",   regs3[31:0], 32'h0);

        // Reset while a P_WAIT=3 write to 0x08 is waiting.
        sel = 1'b1; wr = 1'b1; addr = 32'h08; wdata = 32'hFFFF_FFFF; be = 4'hF;
        @(posedge o_clk); #1;
        @(posedge o_clk); #1;
        rst3 = 1'b1; wr = 1'b0;
        @(posedge o_clk); #1;
        chk("rstw_wq",     if3.s_waitrequest, 1'b1);
        chk("rstw_rdata",  if3.s_readdata, 32'h0);
        chk("rstw_regs",   regs3, 256'h0);
        rst3 = 1'b0;
        @(posedge o_clk); #1;
        @(posedge o_clk); #1;
        chk("rstw_word2",  regs3[2*32 +: 32], 32'h0);
        xact(mk(1, 1, 0, 32'h08, 32'h0, 4'h0, 4, 1, 32'h0, 8'h00), ac, rv, ws);
        chk("rstw_rd_ack", ac, 4);
        chk("rstw_rd_val", rv, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
